// File: rtl/and_tree_driver_pkg.sv
// Shared types and constants for the 27-input AND decoder sweep driver.
// The walking-zero vector space is 28 entries: one all-ones vector plus one per input bit.
package and_tree_driver_pkg;

  localparam int GROUP_W    = 9;
  localparam int NUM_GROUPS = 3;
  localparam int VEC_W      = GROUP_W * NUM_GROUPS;
  localparam int NUM_VEC    = 28;
  localparam int IDX_W      = 5;
  localparam int CNT_W      = 4;

  localparam logic [IDX_W-1:0] NO_FAIL  = 5'd31;
  localparam logic [IDX_W-1:0] LAST_VEC = 5'(NUM_VEC - 1);
  localparam logic [IDX_W-1:0] MAX_ERR  = 5'(NUM_VEC);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_e;

  // Only the all-ones vector may make a healthy AND decoder fire.
  function automatic logic expected_q(input logic [IDX_W-1:0] v);
    return (v == '0);
  endfunction

endpackage

// File: rtl/walk_zero_gen.sv
// Maps a vector index to its 27-bit stimulus: index 0 is all ones,
// index v >= 1 clears bit v-1; indices past the last bit yield all ones.
module walk_zero_gen
  import and_tree_driver_pkg::*;
(
  input  logic [IDX_W-1:0] v,
  output logic [VEC_W-1:0] vec
);

  always_comb begin
    vec = '1;
    for (int i = 0; i < VEC_W; i++) begin
      if (v == IDX_W'(i + 1)) begin
        vec[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/and_tree_driver.sv
// Sweeps a walking-zero pattern over an external 27-input AND decoder and
// records how many vectors disagree with the ideal response and which one failed first.
module and_tree_driver
  import and_tree_driver_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   q,
  output logic [GROUP_W-1:0]     i1,
  output logic [GROUP_W-1:0]     i2,
  output logic [GROUP_W-1:0]     i3,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [IDX_W-1:0]       err_count,
  output logic [IDX_W-1:0]       fail_idx
);

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE - 1);

  state_e            state_q;
  state_e            state_d;
  logic [IDX_W-1:0]  v_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [IDX_W-1:0]  err_q;
  logic [IDX_W-1:0]  fail_q;
  logic [VEC_W-1:0]  vec;
  logic              drive_en;
  logic              mismatch;

  walk_zero_gen u_gen (
    .v   (v_q),
    .vec (vec)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_DRIVE;
      ST_DRIVE:  state_d = ST_SETTLE;
      ST_SETTLE: if (cnt_q == '0) state_d = ST_SAMPLE;
      ST_SAMPLE: state_d = (v_q == LAST_VEC) ? ST_DONE : ST_DRIVE;
      ST_DONE:   if (start) state_d = ST_DRIVE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // q is only ever looked at here, so activity on it in other states is harmless.
  assign mismatch = (q != expected_q(v_q));

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q    <= '0;
      cnt_q  <= '0;
      err_q  <= '0;
      fail_q <= NO_FAIL;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            v_q    <= '0;
            err_q  <= '0;
            fail_q <= NO_FAIL;
          end
        end
        ST_DRIVE: begin
          cnt_q <= SETTLE_LOAD;
        end
        ST_SETTLE: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_SAMPLE: begin
          if (mismatch) begin
            if (err_q != MAX_ERR) begin
              err_q <= err_q + 1'b1;
            end
            if (fail_q == NO_FAIL) begin
              fail_q <= v_q;
            end
          end
          if (v_q != LAST_VEC) begin
            v_q <= v_q + 1'b1;
          end
        end
        default: begin
          v_q <= v_q;
        end
      endcase
    end
  end

  always_comb begin
    drive_en = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      ST_DRIVE, ST_SETTLE, ST_SAMPLE: begin
        drive_en = 1'b1;
        busy     = 1'b1;
      end
      ST_DONE: done = 1'b1;
      default: begin
        drive_en = 1'b0;
      end
    endcase
  end

  // Idle drive is all zeros so the decoder under test stays inactive.
  assign i1        = drive_en ? vec[GROUP_W-1:0]           : '0;
  assign i2        = drive_en ? vec[2*GROUP_W-1:GROUP_W]   : '0;
  assign i3        = drive_en ? vec[3*GROUP_W-1:2*GROUP_W] : '0;
  assign pass      = done && (err_q == '0);
  assign err_count = err_q;
  assign fail_idx  = fail_q;

endmodule
